// File: rtl/sign_count_pkg.sv
// Shared types for the sign-statistics frame sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum and the 2-bit sample class codes produced by
// sign_classifier and consumed by the counters in sign_frame_sequencer.
package sign_count_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

   localparam logic [1:0] CLS_NEG  = 2'd0;
   localparam logic [1:0] CLS_ZERO = 2'd1;
   localparam logic [1:0] CLS_POS  = 2'd2;

endpackage

// File: rtl/sign_classifier.sv
// Classifies one two's-complement sample as negative, zero or positive.
// Latency: combinational.
// Backpressure: none; pure function of the input.
//
// Ports:
//   data  in  N  signed sample
//   cls   out 2  class code (CLS_NEG / CLS_ZERO / CLS_POS)
module sign_classifier
   import sign_count_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] data,
   output logic [1:0]   cls
);

   always_comb begin
      cls = CLS_POS;
      if (data[N-1]) begin
         cls = CLS_NEG;
      end else if (data == '0) begin
         cls = CLS_ZERO;
      end
   end

endmodule

// File: rtl/sign_frame_sequencer.sv
// Pulls a bounded frame of samples, counts negative/zero/positive, reports result.
// Latency: out_valid rises the cycle after the last sample handshake.
// Backpressure: in_ready only in COLLECT; result held in REPORT until out_ready.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, frame_len            frame request and its sample count (0 = ignored)
//   abort                       cancel current frame from any state
//   in_valid/in_ready/in_data   sample stream
//   out_valid/out_ready         result handshake
//   neg/zero/pos_count          result counts
//   busy                        frame in progress or result pending
module sign_frame_sequencer
   import sign_count_pkg::*;
#(
   parameter int N     = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LEN_W-1:0] neg_count,
   output logic [LEN_W-1:0] zero_count,
   output logic [LEN_W-1:0] pos_count,
   output logic             busy
);

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [1:0]       cls;

   sign_classifier #(.N(N)) u_cls (
      .data (in_data),
      .cls  (cls)
   );

   // Handshake outputs decode straight from the state register, so there is
   // no path from any input to any output.
   assign in_ready  = (state == COLLECT);
   assign out_valid = (state == REPORT);
   assign busy      = (state != IDLE);

   logic start_ok;
   assign start_ok = start && (frame_len != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         remaining  <= '0;
         neg_count  <= '0;
         zero_count <= '0;
         pos_count  <= '0;
      end else if (abort) begin
         // Abort wins over everything, including a sample handshaking this cycle.
         state      <= IDLE;
         remaining  <= '0;
         neg_count  <= '0;
         zero_count <= '0;
         pos_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state      <= COLLECT;
                  remaining  <= frame_len;
                  neg_count  <= '0;
                  zero_count <= '0;
                  pos_count  <= '0;
               end
            end
            COLLECT: begin
               if (in_valid) begin
                  case (cls)
                     CLS_NEG:  neg_count  <= neg_count  + LEN_W'(1);
                     CLS_ZERO: zero_count <= zero_count + LEN_W'(1);
                     default:  pos_count  <= pos_count  + LEN_W'(1);
                  endcase
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state <= REPORT;
                  end
               end
            end
            REPORT: begin
               if (out_ready) begin
                  if (start_ok) begin
                     // Back-to-back frame: skip IDLE entirely.
                     state      <= COLLECT;
                     remaining  <= frame_len;
                     neg_count  <= '0;
                     zero_count <= '0;
                     pos_count  <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sign_frame_sequencer.sv
// Directed bench for sign_frame_sequencer: hand-computed expectations checked
// with immediate assertions; inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_sign_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] frame_len = 8'd0;
   logic       abort = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] neg_count, zero_count, pos_count;
   logic       busy;

   int n_assert = 0;
   int n_fail   = 0;

   sign_frame_sequencer #(.N(8), .LEN_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .frame_len  (frame_len),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .neg_count  (neg_count),
      .zero_count (zero_count),
      .pos_count  (pos_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // exp = {in_ready, out_valid, busy}
   task automatic check_flags(input string tag, input logic [2:0] exp);
      logic [2:0] obs;
      obs = {in_ready, out_valid, busy};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: {in_ready,out_valid,busy} observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_counts(input string tag, input logic [7:0] n, input logic [7:0] z,
                               input logic [7:0] p);
      logic [23:0] obs;
      logic [23:0] exp;
      obs = {neg_count, zero_count, pos_count};
      exp = {n, z, p};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: neg/zero/pos observed %0d/%0d/%0d expected %0d/%0d/%0d",
                tag, obs[23:16], obs[15:8], obs[7:0], n, z, p);
      end
   endtask

   task automatic send(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic start_frame(input logic [7:0] len);
      start     = 1'b1;
      frame_len = len;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset
      tick();
      check_flags("reset_flags", 3'b000);
      check_counts("reset_counts", 8'd0, 8'd0, 8'd0);
      rst_n = 1'b1;
      tick();
      check_flags("idle_after_reset", 3'b000);

      // Test 1: len=4, 0x80,0x00,0x7F,0xFF -> neg2 zero1 pos1
      start_frame(8'd4);
      check_flags("t1_collect", 3'b101);
      send(8'h80);
      send(8'h00);
      send(8'h7F);
      check_flags("t1_before_last", 3'b101);
      send(8'hFF);
      check_flags("t1_report", 3'b011);
      check_counts("t1_counts", 8'd2, 8'd1, 8'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_flags("t1_idle", 3'b000);

      // Test 2: len=3 with 2-cycle gaps, out_ready held off 5 cycles
      start_frame(8'd3);
      tick();
      tick();
      check_counts("t2_gap_hold", 8'd0, 8'd0, 8'd0);
      check_flags("t2_gap_state", 3'b101);
      send(8'h05);
      tick();
      tick();
      send(8'h80);
      tick();
      tick();
      check_counts("t2_gap_hold2", 8'd1, 8'd0, 8'd1);
      send(8'h00);
      in_valid = 1'b1;
      in_data  = 8'h01;
      for (int i = 0; i < 5; i++) begin
         check_flags("t2_report_wait", 3'b011);
         check_counts("t2_report_stable", 8'd1, 8'd1, 8'd1);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_flags("t2_idle", 3'b000);
      check_counts("t2_counts_kept", 8'd1, 8'd1, 8'd1);

      // Test 3: start with len=0 is ignored
      start_frame(8'd0);
      check_flags("t3_len0", 3'b000);
      tick();
      check_flags("t3_len0_hold", 3'b000);

      // Test 4: abort mid-frame, sample in abort cycle discarded
      start_frame(8'd8);
      send(8'h10);
      send(8'h80);
      send(8'h00);
      check_counts("t4_pre_abort", 8'd1, 8'd1, 8'd1);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h01;
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      check_flags("t4_abort_idle", 3'b000);
      check_counts("t4_abort_counts", 8'd0, 8'd0, 8'd0);
      tick();
      check_flags("t4_no_out_valid", 3'b000);
      start_frame(8'd2);
      send(8'h01);
      send(8'h01);
      check_flags("t4_report", 3'b011);
      check_counts("t4_pos2", 8'd0, 8'd0, 8'd2);

      // Test 5: back-to-back frame from REPORT
      out_ready = 1'b1;
      start_frame(8'd2);
      out_ready = 1'b0;
      check_flags("t5_b2b_collect", 3'b101);
      check_counts("t5_b2b_cleared", 8'd0, 8'd0, 8'd0);
      send(8'hFE);
      send(8'h00);
      check_flags("t5_report", 3'b011);
      check_counts("t5_counts", 8'd1, 8'd1, 8'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_flags("t5_idle", 3'b000);

      // Test 6: max frame, then async reset mid-COLLECT
      start_frame(8'd255);
      in_valid = 1'b1;
      in_data  = 8'h80;
      for (int i = 0; i < 254; i++) tick();
      check_flags("t6_still_collect", 3'b101);
      check_counts("t6_254", 8'd254, 8'd0, 8'd0);
      tick();
      in_valid = 1'b0;
      check_flags("t6_report", 3'b011);
      check_counts("t6_neg255", 8'd255, 8'd0, 8'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      start_frame(8'd10);
      send(8'h01);
      send(8'h81);
      check_flags("t6_pre_reset", 3'b101);
      rst_n = 1'b0;
      #1;
      check_flags("t6_async_reset_flags", 3'b000);
      check_counts("t6_async_reset_counts", 8'd0, 8'd0, 8'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check_flags("t6_idle_after_reset", 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
